// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter frame-state encoding.
`timescale 1ns/1ps
package uart_pkg;

    // Frame phases: waiting for a start edge, checking the start bit,
    // shifting data bits, checking the stop bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for bringing an asynchronous level
// into the clk domain. Both flops reset to RESET_VAL.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw input through two flops; the second flop's output is safe to use.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: one start bit, WIDTH data bits MSB first, one or more stop
// bits, no parity. Bits are sampled once, SAMPLE_PHASE cycles into each bit
// period measured from the detected start edge. Good words are presented
// on o_data with a one-cycle o_data_valid pulse the cycle after the update.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DIVISOR      = 4,
    parameter int SAMPLE_PHASE = DIVISOR / 2
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_data_valid
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam int IDX_W = $clog2(WIDTH + 1);

    // Counter values at which the current edge is a sample point.
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(SAMPLE_PHASE - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WIDTH - 1);

    logic rx_s;

    uart_state_e       state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [WIDTH-1:0]  shift_q,  shift_d;
    logic [WIDTH-1:0]  data_q,   data_d;
    logic              pend_q,   pend_d;
    logic              valid_q,  valid_d;
    logic              prev_q,   prev_d;
    logic [1:0]        settle_q, settle_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_i (i_reset),
        .d_i   (i_rx),
        .q_o   (rx_s)
    );

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            prev_q   <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            prev_q   <= prev_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic: edge detect, bit timing, shifting and frame check.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        pend_d   = 1'b0;
        valid_d  = pend_q;
        // The synchroniser holds its reset value for two cycles after reset,
        // which is not a real high level; keep the edge detector's history
        // low until the synchroniser reflects the pin, so a line that is
        // already low after reset must go high and fall again to arm.
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        prev_d   = (settle_q == 2'd2) ? rx_s : 1'b0;

        case (state_q)
            IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (cnt_q == PHASE_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = (shift_q << 1) | WIDTH'(rx_s);
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are driven at the pin and a
// scoreboard of expected words and arrival cycles is compared with what
// the receiver reports.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int SP  = 2;
    // Drive at a falling clock edge: one edge to reach the first synchroniser
    // flop, then 2 synchroniser cycles + (S-E) + 1 to the valid pulse.
    localparam int LAT = 1 + 2 + (SP + (W + 1) * DIV) + 1;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_rx;
    logic [W-1:0] o_data;
    logic         o_data_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] obs_q[$];
    int           obs_cyc_q[$];
    logic [W-1:0] last_good;
    logic         prev_v = 1'b0;

    uart_rx #(
        .WIDTH        (W),
        .DIVISOR      (DIV),
        .SAMPLE_PHASE (SP)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_data_valid (o_data_valid)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record every valid pulse; a pulse must never last two cycles.
    always @(negedge clk) begin
        if (o_data_valid === 1'b1) begin
            check("valid_width", {31'd0, prev_v}, 32'd0);
            obs_q.push_back(o_data);
            obs_cyc_q.push_back(cyc);
        end
        prev_v <= o_data_valid;
    end

    // Called at a falling edge; returns at a falling edge with the line high
    // (good stop) or just released high (bad stop), ready for the next frame.
    task automatic send_frame(input logic [W-1:0] d, input bit stop_ok);
        int start_cyc;
        start_cyc = cyc;
        i_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int k = W - 1; k >= 0; k--) begin
            i_rx = d[k];
            repeat (DIV) @(negedge clk);
        end
        i_rx = stop_ok;
        repeat (DIV) @(negedge clk);
        i_rx = 1'b1;
        if (stop_ok) begin
            exp_q.push_back(d);
            exp_cyc_q.push_back(start_cyc + LAT);
            last_good = d;
        end
        $display("frame data=%02h stop_ok=%0d at cycle %0d", d, stop_ok, start_cyc);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Compare everything received so far against the expected words.
    task automatic scoreboard(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
            check({tag, "_cycle"}, obs_cyc_q[i], exp_cyc_q[i]);
        end
        check({tag, "_hold"}, {24'd0, o_data}, {24'd0, last_good});
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    initial begin
        logic [W-1:0] d;
        bit           ok;
        bit           prev_ok;

        i_reset   = 1'b1;
        i_rx      = 1'b1;
        last_good = '0;
        repeat (3) @(negedge clk);
        check("reset_data", {24'd0, o_data}, 32'd0);
        check("reset_valid", {31'd0, o_data_valid}, 32'd0);
        i_reset = 1'b0;
        idle(10);

        // Single word
        send_frame(8'hA5, 1'b1);
        idle(20);
        scoreboard("single");

        // Back-to-back, one stop bit each
        for (int i = 0; i < 4; i++) begin
            send_frame(W'($urandom), 1'b1);
        end
        idle(20);
        scoreboard("b2b");

        // One-clock glitch must not produce a word
        i_rx = 1'b0;
        @(negedge clk);
        idle(30);
        scoreboard("glitch");

        // Framing error followed by a good word
        send_frame(8'h3C, 1'b0);
        idle(12);
        scoreboard("frame_err");
        send_frame(8'h81, 1'b1);
        idle(20);
        scoreboard("after_err");

        // Reset during data bit 3 of 0xFF
        i_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        i_rx = 1'b1;
        repeat (3 * DIV + 2) @(negedge clk);
        i_reset = 1'b1;
        #1;
        check("midreset_data", {24'd0, o_data}, 32'd0);
        check("midreset_valid", {31'd0, o_data_valid}, 32'd0);
        last_good = '0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        idle(50);
        scoreboard("midreset");
        send_frame(8'h5A, 1'b1);
        idle(20);
        scoreboard("post_reset");

        // Line already low across reset must not start a frame
        i_rx = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        last_good = '0;
        repeat (20) @(negedge clk);
        idle(60);
        scoreboard("low_reset");

        // Extremes
        send_frame(8'h00, 1'b1);
        idle(20);
        scoreboard("zeros");
        send_frame(8'hFF, 1'b1);
        idle(20);
        scoreboard("ones");

        // Random words, random gaps, occasional framing errors
        prev_ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d  = W'($urandom);
            ok = ($urandom_range(3) != 0);
            if (!prev_ok) idle(8 + $urandom_range(6));
            else          idle($urandom_range(6));
            send_frame(d, ok);
            prev_ok = ok;
        end
        idle(30);
        scoreboard("random");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
